boot_mem_arbiter: RTL

//  Boot-time sequencer and port arbiter for the byte-addressed MainMemory of the RV32 Core.

---
 rtl/boot_pkg.sv | 27 ++
 rtl/boot_mem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/boot_pkg.sv
// Shared types and helpers for the boot-time memory loader / port arbiter.
package boot_pkg;

    typedef enum logic [1:0] {
        BOOT_IDLE  = 2'd0,
        BOOT_WRITE = 2'd1,
        BOOT_HOLD  = 2'd2,
        BOOT_RUN   = 2'd3
    } boot_state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam logic [15:0] WORD_COUNT_MAX = 16'hFFFF;

    // Big-endian byte select: idx 0 returns the most significant byte.
    function automatic logic [7:0] be_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            2'd3:    b = word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/boot_mem_arbiter.sv
// Boot sequencer and MainMemory write-port arbiter.
// Loads host program words into memory as big-endian bytes while holding the
// core in reset, waits a programmable hold time after the last word, then hands
// the memory port to the core and releases its reset.
module boot_mem_arbiter
    import boot_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned MEM_DEPTH  = 1024,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned RESET_HOLD = 2
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [31:0]       host_data,
    input  logic              host_last,
    input  logic              core_mem_en,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [7:0]        core_wdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              core_reset,
    output logic              load_done,
    output logic [15:0]       word_count,
    output logic              overflow
);

    // Last hold_cnt value spent in HOLD; with no hold time HOLD is skipped entirely.
    localparam logic        HOLD_SKIP = (RESET_HOLD == 0) ? 1'b1 : 1'b0;
    localparam logic [15:0] HOLD_LAST = (RESET_HOLD > 0) ? 16'(RESET_HOLD - 1) : 16'd0;
    localparam logic [ADDR_W:0] MEM_DEPTH_W = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    boot_state_t       r_state;
    boot_state_t       w_next_state;

    logic [31:0]       r_data;
    logic              r_last;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_byte_idx;
    logic [15:0]       r_hold_cnt;
    logic [15:0]       r_word_count;
    logic              r_overflow;
    logic              r_core_reset;
    logic              r_host_ready;
    logic              r_load_done;

    logic              w_accept;
    logic              w_last_byte;
    logic [ADDR_W-1:0] w_word_addr;
    logic [ADDR_W:0]   w_byte_addr_wide;
    logic              w_byte_oob;

    logic              w_mem_en;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [7:0]        w_mem_wdata;

    // Handshake only completes in IDLE with the registered ready asserted.
    assign w_accept    = host_valid && r_host_ready && (r_state == BOOT_IDLE);
    assign w_last_byte = (r_byte_idx == LAST_BYTE);
    assign w_word_addr = ADDR_W'(BASE_ADDR) + ADDR_W'({r_word_count, 2'b00});
    // One extra bit so the range check cannot be fooled by address wrap-around.
    assign w_byte_addr_wide = {1'b0, r_addr} + {{(ADDR_W-1){1'b0}}, r_byte_idx};
    assign w_byte_oob       = (w_byte_addr_wide >= MEM_DEPTH_W);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= BOOT_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: accept -> four byte writes -> (next word | hold | run).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            BOOT_IDLE: begin
                if (w_accept) begin
                    w_next_state = BOOT_WRITE;
                end else begin
                    w_next_state = BOOT_IDLE;
                end
            end
            BOOT_WRITE: begin
                if (!w_last_byte) begin
                    w_next_state = BOOT_WRITE;
                end else if (!r_last) begin
                    w_next_state = BOOT_IDLE;
                end else if (HOLD_SKIP) begin
                    w_next_state = BOOT_RUN;
                end else begin
                    w_next_state = BOOT_HOLD;
                end
            end
            BOOT_HOLD: begin
                if (r_hold_cnt == HOLD_LAST) begin
                    w_next_state = BOOT_RUN;
                end else begin
                    w_next_state = BOOT_HOLD;
                end
            end
            BOOT_RUN: begin
                w_next_state = BOOT_RUN;
            end
            default: begin
                w_next_state = BOOT_IDLE;
            end
        endcase
    end

    // Memory port mux: loader bytes in WRITE, core passthrough in RUN, idle otherwise.
    always_comb begin
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = 8'h00;
        case (r_state)
            BOOT_WRITE: begin
                w_mem_en    = 1'b1;
                w_mem_we    = ~w_byte_oob;
                w_mem_addr  = w_byte_addr_wide[ADDR_W-1:0];
                w_mem_wdata = be_byte(r_data, r_byte_idx);
            end
            BOOT_RUN: begin
                w_mem_en    = core_mem_en;
                w_mem_we    = core_we;
                w_mem_addr  = core_addr;
                w_mem_wdata = core_wdata;
            end
            default: begin
                w_mem_en    = 1'b0;
                w_mem_we    = 1'b0;
                w_mem_addr  = '0;
                w_mem_wdata = 8'h00;
            end
        endcase
    end

    // Latch the accepted word, its last flag and its base byte address.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_data <= 32'h0000_0000;
            r_last <= 1'b0;
            r_addr <= '0;
        end else if (w_accept) begin
            r_data <= host_data;
            r_last <= host_last;
            r_addr <= w_word_addr;
        end else begin
            r_data <= r_data;
            r_last <= r_last;
            r_addr <= r_addr;
        end
    end

    // Byte index within the word: cleared on accept, advances once per WRITE cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_byte_idx <= 2'd0;
        end else if (w_accept) begin
            r_byte_idx <= 2'd0;
        end else if (r_state == BOOT_WRITE) begin
            r_byte_idx <= r_byte_idx + 2'd1;
        end else begin
            r_byte_idx <= r_byte_idx;
        end
    end

    // Hold-time counter, running only while in HOLD.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hold_cnt <= 16'd0;
        end else if (r_state == BOOT_HOLD) begin
            r_hold_cnt <= r_hold_cnt + 16'd1;
        end else begin
            r_hold_cnt <= 16'd0;
        end
    end

    // Saturating count of accepted words and sticky out-of-range flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_word_count <= 16'd0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_accept && (r_word_count != WORD_COUNT_MAX)) begin
                r_word_count <= r_word_count + 16'd1;
            end else begin
                r_word_count <= r_word_count;
            end
            if ((r_state == BOOT_WRITE) && w_byte_oob) begin
                r_overflow <= 1'b1;
            end else begin
                r_overflow <= r_overflow;
            end
        end
    end

    // Registered status outputs derived from the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_core_reset <= 1'b1;
            r_host_ready <= 1'b0;
            r_load_done  <= 1'b0;
        end else begin
            r_core_reset <= (w_next_state != BOOT_RUN);
            r_host_ready <= (w_next_state == BOOT_IDLE);
            r_load_done  <= (w_next_state == BOOT_RUN);
        end
    end

    assign host_ready = r_host_ready;
    assign core_reset = r_core_reset;
    assign load_done  = r_load_done;
    assign word_count = r_word_count;
    assign overflow   = r_overflow;
    assign mem_en     = w_mem_en;
    assign mem_we     = w_mem_we;
    assign mem_addr   = w_mem_addr;
    assign mem_wdata  = w_mem_wdata;

endmodule
